// File: rtl/conv_encoder_stream.sv
// Frame-based 1/N convolutional encoder with automatic zero-tail termination.
// Optional rate-2/3 puncture marking is enabled by defining CONV_ENCODER_PUNCTURE_EN.

module conv_enc_lane #(
  parameter int MAX_K = 9
) (
  input  logic [MAX_K-1:0] poly_i,
  input  logic [MAX_K-1:0] win_i,
  input  logic [MAX_K-1:0] kmask_i,
  input  logic             en_i,
  output logic             bit_o
);
  assign bit_o = en_i & (^(poly_i & win_i & kmask_i));
endmodule

module conv_encoder_stream #(
  parameter int MAX_K       = 9,
  parameter int MAX_N       = 3,
  parameter int FRAME_LEN_W = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_start,
  input  logic [3:0]                        i_constr_len,
  input  logic [1:0]                        i_rate_n,
  input  logic [MAX_N-1:0][MAX_K-1:0]       i_gen_poly,
  input  logic [FRAME_LEN_W-1:0]            i_frame_len,
`ifdef CONV_ENCODER_PUNCTURE_EN
  input  logic                              i_punct,
`endif
  input  logic                              i_valid,
  input  logic                              i_bit,
  output logic                              o_ready,
  output logic                              o_valid,
  output logic [MAX_N-1:0]                  o_data,
  output logic [MAX_N-1:0]                  o_mask,
  output logic                              o_last,
  input  logic                              i_out_ready,
  output logic                              o_busy,
  output logic                              o_err
);

  localparam logic [3:0] MAX_K_L = 4'(MAX_K);
  localparam logic [1:0] MAX_N_L = 2'(MAX_N);

  typedef enum logic [1:0] {IDLE, DATA, TAIL, DONE} state_t;

  typedef struct packed {
    logic [3:0]                  k;
    logic [1:0]                  n;
    logic [MAX_N-1:0][MAX_K-1:0] poly;
  } cfg_t;

  state_t                 state_q;
  cfg_t                   cfg_q;
  logic [MAX_K-2:0]       sr_q;
  logic [FRAME_LEN_W-1:0] cnt_q;
  logic [3:0]             tail_q;
  logic                   valid_q, last_q, err_q;
  logic [MAX_N-1:0]       data_q, mask_q;
`ifdef CONV_ENCODER_PUNCTURE_EN
  logic                   punct_q, par_q;
`endif

  logic             step_ok, in_hs, tail_step, load, cur, cfg_legal;
  logic [MAX_K-1:0] win, kmask;
  logic [MAX_N-1:0] lane_en, sym_d, mask_d;

  // Output buffer may take a new symbol when empty or draining this cycle.
  assign step_ok   = !valid_q || i_out_ready;
  assign o_ready   = (state_q == DATA) && step_ok;
  assign in_hs     = i_valid && o_ready;
  assign tail_step = (state_q == TAIL) && step_ok;
  assign load      = in_hs || tail_step;
  assign cur       = (state_q == DATA) && i_bit;
  assign win       = {sr_q, cur};

  genvar gj, gn;
  generate
    for (gj = 0; gj < MAX_K; gj++) begin : g_kmask
      assign kmask[gj] = (4'(gj) < cfg_q.k);
    end
    for (gn = 0; gn < MAX_N; gn++) begin : g_lane
      assign lane_en[gn] = (2'(gn) < cfg_q.n);
      conv_enc_lane #(.MAX_K(MAX_K)) u_lane (
        .poly_i  (cfg_q.poly[gn]),
        .win_i   (win),
        .kmask_i (kmask),
        .en_i    (lane_en[gn]),
        .bit_o   (sym_d[gn])
      );
    end
  endgenerate

`ifdef CONV_ENCODER_PUNCTURE_EN
  // Odd-indexed symbols of a punctured frame keep only lane 0.
  assign mask_d    = (punct_q && par_q) ? MAX_N'(1) : lane_en;
  assign cfg_legal = (i_constr_len >= 4'd3) && (i_constr_len <= MAX_K_L) &&
                     (i_rate_n >= 2'd2) && (i_rate_n <= MAX_N_L) && (|i_frame_len) &&
                     (!i_punct || (i_rate_n == 2'd2));
`else
  assign mask_d    = lane_en;
  assign cfg_legal = (i_constr_len >= 4'd3) && (i_constr_len <= MAX_K_L) &&
                     (i_rate_n >= 2'd2) && (i_rate_n <= MAX_N_L) && (|i_frame_len);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cfg_q   <= '0;
      sr_q    <= '0;
      cnt_q   <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef CONV_ENCODER_PUNCTURE_EN
      punct_q <= 1'b0;
      par_q   <= 1'b0;
`endif
    end else begin
      if (valid_q && i_out_ready) begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= sym_d;
        mask_q  <= mask_d;
        last_q  <= (state_q == TAIL) && (tail_q == 4'd1);
        sr_q    <= {sr_q[MAX_K-3:0], cur};
`ifdef CONV_ENCODER_PUNCTURE_EN
        par_q   <= ~par_q;
`endif
      end
      case (state_q)
        IDLE: if (i_start) begin
          if (cfg_legal) begin
            cfg_q   <= '{k: i_constr_len, n: i_rate_n, poly: i_gen_poly};
            sr_q    <= '0;
            cnt_q   <= i_frame_len;
            err_q   <= 1'b0;
            state_q <= DATA;
`ifdef CONV_ENCODER_PUNCTURE_EN
            punct_q <= i_punct;
            par_q   <= 1'b0;
`endif
          end else begin
            err_q <= 1'b1;
          end
        end
        DATA: if (in_hs) begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == FRAME_LEN_W'(1)) begin
            tail_q  <= cfg_q.k - 4'd1;
            state_q <= TAIL;
          end
        end
        TAIL: if (step_ok) begin
          tail_q <= tail_q - 4'd1;
          if (tail_q == 4'd1) state_q <= DONE;
        end
        DONE: if (valid_q && i_out_ready) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_mask  = mask_q;
  assign o_last  = last_q;
  assign o_busy  = (state_q != IDLE);
  assign o_err   = err_q;

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Directed bench for conv_encoder_stream: convolution-sum reference model,
// per-cycle output checker, stall injection and literal sequences from hand work.

module tb_conv_encoder_stream;
  localparam int MAX_K = 9;
  localparam int MAX_N = 3;
  localparam int FW    = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_start = 1'b0;
  logic [3:0] i_constr_len = '0;
  logic [1:0] i_rate_n = '0;
  logic [MAX_N-1:0][MAX_K-1:0] i_gen_poly = '0;
  logic [FW-1:0] i_frame_len = '0;
  logic i_valid = 1'b0, i_bit = 1'b0, i_out_ready = 1'b1;
  logic o_ready, o_valid, o_last, o_busy, o_err;
  logic [MAX_N-1:0] o_data, o_mask;
`ifdef CONV_ENCODER_PUNCTURE_EN
  logic i_punct = 1'b0;
`endif

  conv_encoder_stream #(.MAX_K(MAX_K), .MAX_N(MAX_N), .FRAME_LEN_W(FW)) dut (
    .clk(clk), .rst(rst), .i_start(i_start), .i_constr_len(i_constr_len),
    .i_rate_n(i_rate_n), .i_gen_poly(i_gen_poly), .i_frame_len(i_frame_len),
`ifdef CONV_ENCODER_PUNCTURE_EN
    .i_punct(i_punct),
`endif
    .i_valid(i_valid), .i_bit(i_bit), .o_ready(o_ready), .o_valid(o_valid),
    .o_data(o_data), .o_mask(o_mask), .o_last(o_last), .i_out_ready(i_out_ready),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [MAX_N-1:0] d; logic [MAX_N-1:0] m; logic l; } sym_t;
  sym_t exp_q[$];
  logic [MAX_N-1:0] rx_q[$];
  int checks = 0, errors = 0, rx_cnt = 0;
  int last_rx = -1, stall_n = 0;
  bit stall_en = 1'b0, held = 1'b0;
  logic [MAX_N-1:0] hd;
  logic hl;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reference: symbol t, lane n = XOR_j poly[n][j] * u[t-j], u zero outside the frame.
  function automatic void build(int k, int n, logic [MAX_N-1:0][MAX_K-1:0] p,
                                int len, logic [15:0] b, bit pu);
    sym_t s;
    int tot;
    tot = len + k - 1;
    exp_q.delete();
    for (int t = 0; t < tot; t++) begin
      s.d = '0;
      for (int ln = 0; ln < n; ln++)
        for (int j = 0; j < k; j++)
          if (t - j >= 0 && t - j < len) s.d[ln] ^= p[ln][j] & b[t-j];
      s.m = (pu && (t % 2 == 1)) ? 3'b001 : 3'((1 << n) - 1);
      s.l = (t == tot - 1);
      exp_q.push_back(s);
    end
  endfunction

  always @(posedge clk) begin
    #1;
    if (rx_cnt != last_rx) begin stall_n = 0; last_rx = rx_cnt; end
    if (stall_en && o_valid && (rx_cnt == 1 || rx_cnt == 5) && stall_n < 3) begin
      i_out_ready = 1'b0;
      stall_n++;
    end else begin
      i_out_ready = 1'b1;
    end
  end

  always @(negedge clk) begin
    sym_t e;
    if (!rst) begin
      held = 1'b0;
    end else begin
      if (held) begin
        chk("hold_valid", 32'(o_valid), 32'd1);
        chk("hold_data", 32'(o_data), 32'(hd));
        chk("hold_last", 32'(o_last), 32'(hl));
      end
      held = o_valid && !i_out_ready;
      if (held) begin
        hd = o_data; hl = o_last;
        chk("stall_ready", 32'(o_ready), 32'd0);
      end
      if (o_valid && i_out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL extra_symbol got %0h want none", o_data);
        end else begin
          e = exp_q.pop_front();
          chk("sym_data", 32'(o_data), 32'(e.d));
          chk("sym_mask", 32'(o_mask), 32'(e.m));
          chk("sym_last", 32'(o_last), 32'(e.l));
        end
        rx_q.push_back(o_data);
        rx_cnt++;
      end
    end
  end

  task automatic start(int k, int n, logic [MAX_N-1:0][MAX_K-1:0] p, int len, bit pu);
    @(posedge clk); #1;
    i_constr_len = 4'(k); i_rate_n = 2'(n); i_gen_poly = p; i_frame_len = FW'(len);
`ifdef CONV_ENCODER_PUNCTURE_EN
    i_punct = pu;
`endif
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
  endtask

  task automatic feed(int len, logic [15:0] b);
    int idx = 0, guard = 0;
    while (idx < len && guard < 200) begin
      i_valid = 1'b1; i_bit = b[idx];
      @(negedge clk);
      if (o_ready) idx++;
      @(posedge clk); #1;
      guard++;
    end
    i_valid = 1'b0;
    chk("feed_done", 32'(idx), 32'(len));
  endtask

  task automatic wait_idle();
    int guard = 0;
    while (o_busy && guard < 100) begin @(posedge clk); #1; guard++; end
    chk("idle_timeout", 32'(o_busy), 32'd0);
  endtask

  task automatic run(int k, int n, logic [MAX_N-1:0][MAX_K-1:0] p, int len,
                     logic [15:0] b, bit pu);
    rx_cnt = 0; rx_q.delete();
    build(k, n, p, len, b, pu);
    start(k, n, p, len, pu);
    chk("start_busy", 32'(o_busy), 32'd1);
    chk("start_err", 32'(o_err), 32'd0);
    feed(len, b);
    wait_idle();
    chk("sym_count", 32'(rx_cnt), 32'(len + k - 1));
    chk("model_drained", 32'(exp_q.size()), 32'd0);
  endtask

  logic [MAX_N-1:0] lit1 [6];
  logic [MAX_N-1:0][MAX_K-1:0] p1, p9, p5;

  task automatic chk_lit1(string nm);
    chk({nm, "_len"}, 32'(rx_q.size()), 32'd6);
    for (int i = 0; i < 6; i++) chk(nm, 32'(rx_q[i]), 32'(lit1[i]));
  endtask

  initial begin
    lit1 = '{3'b011, 3'b001, 3'b000, 3'b010, 3'b010, 3'b011};
    // Lane 0 has taps beyond K=3 and lane 2 is beyond N=2; both must be ignored.
    p1 = {9'h1FF, 9'b000000101, 9'h1FF};
    p9 = {9'h1FF, 9'h1FF, 9'h1FF};
    p5 = {9'b000010111, 9'b000011101, 9'b000010011};

    #12;
    chk("rst_ready", 32'(o_ready), 0); chk("rst_valid", 32'(o_valid), 0);
    chk("rst_data", 32'(o_data), 0);   chk("rst_mask", 32'(o_mask), 0);
    chk("rst_last", 32'(o_last), 0);   chk("rst_busy", 32'(o_busy), 0);
    chk("rst_err", 32'(o_err), 0);
    @(negedge clk); rst = 1'b1;

    run(3, 2, p1, 4, 16'b1101, 1'b0);
    chk_lit1("t1_lit");

    stall_en = 1'b1;
    run(3, 2, p1, 4, 16'b1101, 1'b0);
    chk_lit1("t2_stall_lit");
    stall_en = 1'b0;

    start(2, 2, p1, 4, 1'b0);
    chk("bad_k_err", 32'(o_err), 1); chk("bad_k_busy", 32'(o_busy), 0);
    start(3, 1, p1, 4, 1'b0);
    chk("bad_n_err", 32'(o_err), 1); chk("bad_n_busy", 32'(o_busy), 0);
    start(3, 2, p1, 0, 1'b0);
    chk("bad_len_err", 32'(o_err), 1); chk("bad_len_busy", 32'(o_busy), 0);
    run(3, 2, p1, 4, 16'b1101, 1'b0);
    chk_lit1("t3_after_err");

    run(9, 3, p9, 1, 16'b1, 1'b0);
    for (int i = 0; i < 9; i++) chk("k9_lit", 32'(rx_q[i]), 32'h7);

    run(5, 3, p5, 10, 16'b1011001110, 1'b0);

    rx_cnt = 0; rx_q.delete();
    build(3, 2, p1, 4, 16'b1101, 1'b0);
    start(3, 2, p1, 4, 1'b0);
    feed(4, 16'b1101);
    rst = 1'b0;
    #1;
    chk("abort_valid", 32'(o_valid), 0); chk("abort_busy", 32'(o_busy), 0);
    chk("abort_last", 32'(o_last), 0);   chk("abort_ready", 32'(o_ready), 0);
    exp_q.delete();
    @(negedge clk); rst = 1'b1;
    run(3, 2, p1, 4, 16'b1101, 1'b0);
    chk_lit1("t5_after_abort");

`ifdef CONV_ENCODER_PUNCTURE_EN
    start(3, 3, p1, 4, 1'b1);
    chk("punct_n3_err", 32'(o_err), 1); chk("punct_n3_busy", 32'(o_busy), 0);
    run(3, 2, p1, 4, 16'b1101, 1'b1);
    chk_lit1("t6_punct_lit");
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
endmodule

// File: doc/conv_encoder_stream.md
Name: conv_encoder_stream

Overview:
- Parametrised, frame-based convolutional encoder. It is the next generation of the encode path inside the encoder/decoder top.
- Configurable code rate 1/N (N up to MAX_N) and constraint length K (up to MAX_K) per frame.
- Valid/ready handshakes on both sides. Automatic zero-tail termination so the decoder's traceback always ends in state 0.
- Sits between the PS-side bit source and the channel/slice stage. It replaces the fixed-rate, unframed encoder when its outputs are registered.

Parameters:
- MAX_K, 9, maximum constraint length; shift register depth MAX_K-1.
- MAX_N, 3, maximum code-rate denominator (number of output lanes).
- FRAME_LEN_W, 16, width of the frame-length field.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- i_start  in  1  one-cycle pulse; latches config, starts a frame (honoured only in IDLE)
- i_constr_len  in  4  K for this frame; legal range 3..MAX_K
- i_rate_n  in  2  N for this frame; legal range 2..MAX_N
- i_gen_poly  in  MAX_N x MAX_K  generator polynomials; lane n, bit j taps the input delayed j cycles
- i_frame_len  in  FRAME_LEN_W  number of information bits; legal range 1..2^FRAME_LEN_W-1
- i_valid  in  1  input bit valid
- i_bit  in  1  information bit
- o_ready  out  1  encoder accepts i_bit this cycle
- o_valid  out  1  output symbol valid
- o_data  out  MAX_N  coded symbol; lane n = bit n
- o_mask  out  MAX_N  lanes carrying information in o_data
- o_last  out  1  marks final symbol of frame
- i_out_ready  in  1  downstream accepts symbol
- o_busy  out  1  state != IDLE
- o_err  out  1  sticky illegal-config flag; cleared by next legal i_start

Behaviour:
- Reset (async, rst=0): state IDLE, shift register 0, counters 0. Outputs: o_ready=0, o_valid=0, o_data=0, o_mask=0, o_last=0, o_busy=0, o_err=0.
- States are IDLE, DATA, TAIL, DONE.
- IDLE -> DATA on i_start with legal config:
  - config registered; shift register cleared; bit counter = i_frame_len.
  - Illegal config (K out of range, N out of range, frame_len=0): set o_err, stay IDLE.
  - i_start outside IDLE is ignored.
- Encoding window: w[0] = current bit, w[j] = bit j steps earlier (j = 1..K-1).
  - o_data[n] = XOR over j<K of (i_gen_poly[n][j] & w[j]) for n<N.
  - Lanes n>=N are 0. Poly bits j>=K are ignored.
- Output register: single-entry buffer. It is loaded on a step and held stable while o_valid=1 and i_out_ready=0.
  - step allowed = !o_valid || i_out_ready.
  - o_valid clears after the transfer if no new step occurs.
- DATA: o_ready = step allowed. An input handshake (i_valid & o_ready) encodes i_bit, shifts the register, and decrements the counter.
  - When the counter reaches 0: to TAIL if K>1 (always, given legal K), tail counter = K-1.
- TAIL: o_ready=0. On each step allowed, encode a zero bit and decrement the tail counter.
  - The last tail symbol asserts o_last with its o_valid.
  - Then go to DONE.
- DONE: wait for the o_last symbol to transfer, then go to IDLE. The next i_start is accepted the cycle after.
- Latency: symbol appears on o_data one cycle after its input handshake or tail step.
- Throughput: one symbol per cycle with i_out_ready held high. Total symbols per frame = frame_len + K - 1.
- o_mask = lanes 0..N-1 set, registered with o_data.
- Backpressure mid-TAIL: tail counter and o_last hold unchanged until transfer.
- i_valid with o_ready=0: no effect; source must hold.
- Reset mid-frame aborts immediately to the reset values. No partial o_last.

Optional Feature:
- Macro: CONV_ENCODER_PUNCTURE_EN.
- When defined: extra input port i_punct (1 bit), latched at i_start and legal only with N=2 (else o_err).
  - When set, rate-2/3 puncturing applies: odd-indexed symbols within the frame (index counted from 0, tail included) get o_mask=2'b01. Even-indexed symbols get 2'b11.
  - o_data is unchanged; only the mask marks dropped lanes.
- When not defined: the port is absent and o_mask is always the N-lane mask.

Test Plan:
- K=3, N=2, poly lane0=3'b111, lane1=3'b101, frame_len=4, bits 1,0,1,1, i_out_ready=1 -> o_data sequence 2'b11, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11; o_last only on the 6th; o_mask=2'b11; then o_busy drops.
- Same frame with i_out_ready low for 3 cycles at the 2nd symbol and again at the 6th -> o_data/o_last held stable; o_ready=0 while stalled; identical sequence.
- i_start with i_constr_len=2, or i_rate_n=1, or frame_len=0 -> o_err=1, o_busy stays 0. A following legal i_start -> o_err=0, frame runs.
- K=9, N=3, frame_len=1, bit 1, polys all-ones -> 9 symbols: first 3'b111, then 3'b111 x8 (zeros fed, 1 still in window); o_last on the 9th.
- rst low during TAIL of the first test -> o_valid=0, o_busy=0 immediately. A new frame after reset reproduces the first-test sequence exactly.
- CONV_ENCODER_PUNCTURE_EN defined, first test with i_punct=1 -> o_mask 11,01,11,01,11,01; o_data as in the first test.
